// File: rtl/pushbutton_irq_servicer_pkg.sv
// Shared types and helpers for the pushbutton PIO interrupt servicer.
package pushbutton_irq_servicer_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_CLR,
        ST_EMIT,
        ST_MASK_WR
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : (value + 32'd1);
    endfunction

endpackage

// File: rtl/pushbutton_irq_servicer_press_counter_bank.sv
// Bank of per-button saturating press counters, flattened onto one output bus.
module press_counter_bank
    import pushbutton_irq_servicer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         i_inc,
    output logic [WIDTH*CNT_W-1:0]   o_count
);

    logic [CNT_W-1:0] r_cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_inc[i]) begin
                    r_cnt[i] <= CNT_W'(sat_inc(32'(r_cnt[i]), CNT_W));
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_out
        assign o_count[g*CNT_W +: CNT_W] = r_cnt[g];
    end

endmodule

// File: rtl/pushbutton_irq_servicer.sv
// Avalon-MM master that services the pushbutton PIO interrupt and turns each
// service into a valid/ready button event, with per-button press counters.
module pushbutton_irq_servicer
    import pushbutton_irq_servicer_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] INIT_MASK = WIDTH'(4'hF),
    parameter int               CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [1:0]             avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write_n,
    output logic [31:0]            avm_writedata,
    input  logic [31:0]            avm_readdata,
    input  logic                   irq,
    input  logic                   mask_set,
    input  logic [WIDTH-1:0]       mask_value,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [WIDTH-1:0]       event_buttons,
    output logic [WIDTH*CNT_W-1:0] press_count,
    output logic                   busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_evt_btn;
    logic             r_evt_vld;
    logic [1:0]       r_addr_last;

    logic             w_cs;
    logic             w_wr;
    logic [1:0]       w_addr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_cs_g;
    logic             w_wr_g;
    logic             w_accept;
    logic [WIDTH-1:0] w_inc;
    logic             w_unused_rd;

    assign w_unused_rd = ^avm_readdata[31:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:    w_next = ST_IDLE;
            ST_IDLE: begin
                if (mask_set) begin
                    w_next = ST_MASK_WR;
                end else if (irq) begin
                    w_next = ST_RD_ADDR;
                end
            end
            ST_MASK_WR: w_next = ST_IDLE;
            ST_RD_ADDR: w_next = ST_RD_WAIT;
            ST_RD_WAIT: w_next = ST_CLR;
            ST_CLR:     w_next = (r_cap == '0) ? ST_IDLE : ST_EMIT;
            ST_EMIT: begin
                if (event_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_cs    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = r_addr_last;
        w_wdata = '0;
        case (r_state)
            ST_INIT, ST_MASK_WR: begin
                w_cs    = 1'b1;
                w_wr    = 1'b1;
                w_addr  = ADDR_MASK;
                w_wdata = r_mask;
            end
            ST_RD_ADDR: begin
                w_cs   = 1'b1;
                w_addr = ADDR_EDGE;
            end
            ST_CLR: begin
                w_cs    = 1'b1;
                w_wr    = 1'b1;
                w_addr  = ADDR_EDGE;
                w_wdata = r_cap;
            end
            default: ;
        endcase
    end

    // Bus strobes are qualified by reset so the bus stays idle while held in reset,
    // yet the INIT write appears in the very first cycle after release.
    assign w_cs_g         = w_cs & reset_n;
    assign w_wr_g         = w_wr & reset_n;
    assign avm_chipselect = w_cs_g;
    assign avm_write_n    = ~w_wr_g;
    assign avm_address    = w_cs_g ? w_addr : r_addr_last;
    assign avm_writedata  = {{(32-WIDTH){1'b0}}, (w_wr_g ? w_wdata : {WIDTH{1'b0}})};
    assign busy           = reset_n & (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_last <= ADDR_DATA;
        end else if (w_cs) begin
            r_addr_last <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= INIT_MASK;
        end else if (r_state == ST_IDLE && mask_set) begin
            r_mask <= mask_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else if (r_state == ST_RD_WAIT) begin
            r_cap <= avm_readdata[WIDTH-1:0] & r_mask;
        end
    end

    assign w_accept = (r_state == ST_EMIT) && event_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_vld <= 1'b0;
            r_evt_btn <= '0;
        end else if (r_state == ST_CLR && r_cap != '0) begin
            r_evt_vld <= 1'b1;
            r_evt_btn <= r_cap;
        end else if (w_accept) begin
            r_evt_vld <= 1'b0;
        end
    end

    assign event_valid   = r_evt_vld;
    assign event_buttons = r_evt_btn;
    assign w_inc         = w_accept ? r_evt_btn : '0;

    press_counter_bank #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counters (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_inc),
        .o_count (press_count)
    );

endmodule

// File: tb/tb_pushbutton_irq_servicer.sv
// Scoreboard bench for pushbutton_irq_servicer with a small registered PIO slave model.
module tb_pushbutton_irq_servicer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [1:0]             avm_address;
    logic                   avm_chipselect;
    logic                   avm_write_n;
    logic [31:0]            avm_writedata;
    logic [31:0]            avm_readdata;
    logic                   irq;
    logic                   mask_set = 1'b0;
    logic [WIDTH-1:0]       mask_value = '0;
    logic                   event_valid;
    logic                   event_ready = 1'b1;
    logic [WIDTH-1:0]       event_buttons;
    logic [WIDTH*CNT_W-1:0] press_count;
    logic                   busy;

    pushbutton_irq_servicer #(.WIDTH(WIDTH), .INIT_MASK(4'hF), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .irq            (irq),
        .mask_set       (mask_set),
        .mask_value     (mask_value),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_buttons  (event_buttons),
        .press_count    (press_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // PIO slave model: registered read, write-1-to-clear edge capture, irq mask.
    logic [WIDTH-1:0] pio_edge;
    logic [WIDTH-1:0] pio_mask;
    logic [WIDTH-1:0] pio_clr;
    logic [WIDTH-1:0] press_req = '0;
    logic             force_irq = 1'b0;

    assign pio_clr = (avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata[WIDTH-1:0] : '0;
    assign irq     = (|(pio_edge & pio_mask)) | force_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_edge     <= '0;
            pio_mask     <= '0;
            avm_readdata <= '0;
        end else begin
            if (avm_chipselect && avm_write_n)
                avm_readdata <= (avm_address == 2'd3) ? {28'd0, pio_edge} : 32'd0;
            pio_edge <= (pio_edge & ~pio_clr) | press_req;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                pio_mask <= avm_writedata[WIDTH-1:0];
        end
    end

    typedef struct packed {
        logic        evt;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } item_t;

    item_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic item_t mk(input logic evt, input logic wr, input logic [1:0] addr, input logic [31:0] data);
        item_t it;
        it.evt  = evt;
        it.wr   = wr;
        it.addr = addr;
        it.data = data;
        return it;
    endfunction

    task automatic exp_wr(input logic [1:0] addr, input logic [31:0] data);
        exp_q.push_back(mk(1'b0, 1'b1, addr, data));
    endtask

    task automatic exp_rd();
        exp_q.push_back(mk(1'b0, 1'b0, 2'd3, 32'd0));
    endtask

    task automatic exp_evt(input logic [31:0] btn);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, btn));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic sb_cmp(input item_t got);
        item_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: actual evt=%0d wr=%0d addr=%0d data=0x%0h required=nothing",
                     got.evt, got.wr, got.addr, got.data);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL sb_item: actual evt=%0d wr=%0d addr=%0d data=0x%0h required evt=%0d wr=%0d addr=%0d data=0x%0h",
                         got.evt, got.wr, got.addr, got.data, e.evt, e.wr, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every bus access and every rising event_valid is checked against the queue.
    logic             prev_vld = 1'b0;
    logic [WIDTH-1:0] prev_btn = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_chipselect)
                sb_cmp(mk(1'b0, !avm_write_n, avm_address, avm_write_n ? 32'd0 : avm_writedata));
            if (event_valid && !prev_vld)
                sb_cmp(mk(1'b1, 1'b0, 2'd0, {28'd0, event_buttons}));
            if (event_valid && prev_vld)
                chk("evt_stable", {28'd0, event_buttons}, {28'd0, prev_btn});
        end
        prev_vld = event_valid;
        prev_btn = event_buttons;
    end

    task automatic press(input logic [WIDTH-1:0] btn);
        @(posedge clk); #1 press_req = btn;
        @(posedge clk); #1 press_req = '0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!event_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("evt_timeout", {31'd0, event_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state
        exp_wr(2'd2, 32'h0000_000F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs",     {31'd0, avm_chipselect}, 32'd0);
        chk("rst_wr_n",   {31'd0, avm_write_n},    32'd1);
        chk("rst_addr",   {30'd0, avm_address},    32'd0);
        chk("rst_wdata",  avm_writedata,           32'd0);
        chk("rst_valid",  {31'd0, event_valid},    32'd0);
        chk("rst_busy",   {31'd0, busy},           32'd0);
        chk("rst_count",  press_count,             32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Button 1 press with latency check
        exp_rd(); exp_wr(2'd3, 32'h2); exp_evt(32'h2);
        press(4'h2);
        @(negedge clk);
        chk("irq_seen", {31'd0, irq}, 32'd1);
        lat = 0;
        while (!event_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 32'd4);
        chk("btn1_buttons", {28'd0, event_buttons}, 32'h2);
        @(negedge clk);
        chk("btn1_valid_drop", {31'd0, event_valid}, 32'd0);
        chk("btn1_count", {24'd0, press_count[15:8]}, 32'd1);

        // Spurious irq
        exp_rd(); exp_wr(2'd3, 32'h0);
        @(posedge clk); #1 force_irq = 1'b1;
        @(posedge clk); #1 force_irq = 1'b0;
        repeat (6) @(negedge clk);
        chk("spur_valid", {31'd0, event_valid}, 32'd0);
        chk("spur_busy",  {31'd0, busy},        32'd0);

        // Back-pressure with a second press arriving during EMIT
        event_ready = 1'b0;
        exp_rd(); exp_wr(2'd3, 32'h1); exp_evt(32'h1);
        exp_rd(); exp_wr(2'd3, 32'h8); exp_evt(32'h8);
        press(4'h1);
        wait_valid(20);
        press(4'h8);
        repeat (10) @(negedge clk);
        chk("hold_valid",   {31'd0, event_valid},      32'd1);
        chk("hold_buttons", {28'd0, event_buttons},    32'h1);
        chk("hold_busy",    {31'd0, busy},             32'd1);
        event_ready = 1'b1;
        repeat (2) @(negedge clk);
        wait_valid(20);
        chk("second_buttons", {28'd0, event_buttons}, 32'h8);
        repeat (3) @(negedge clk);
        chk("cnt0_after_hold", {24'd0, press_count[7:0]},   32'd1);
        chk("cnt1_after_hold", {24'd0, press_count[15:8]},  32'd1);
        chk("cnt3_after_hold", {24'd0, press_count[31:24]}, 32'd1);

        // mask_set and irq in the same IDLE cycle
        exp_wr(2'd2, 32'h5); exp_rd(); exp_wr(2'd3, 32'h5); exp_evt(32'h5);
        @(posedge clk); #1 press_req = 4'hF;
        @(posedge clk); #1 press_req = '0; mask_set = 1'b1; mask_value = 4'h5;
        @(posedge clk); #1 mask_set = 1'b0;
        wait_valid(20);
        chk("mask_buttons", {28'd0, event_buttons}, 32'h5);
        repeat (3) @(negedge clk);
        chk("cnt0_after_mask", {24'd0, press_count[7:0]},   32'd2);
        chk("cnt2_after_mask", {24'd0, press_count[23:16]}, 32'd1);

        // Saturation of button 0 (bits 1 and 3 stay latched but masked)
        for (int i = 0; i < 300; i++) begin
            exp_rd(); exp_wr(2'd3, 32'h1); exp_evt(32'h1);
            press(4'h1);
            repeat (8) @(posedge clk);
            if (i == 100)
                chk("cnt0_mid", {24'd0, press_count[7:0]}, 32'd103);
        end
        @(negedge clk);
        chk("cnt0_sat", {24'd0, press_count[7:0]},   32'd255);
        chk("cnt2_sat", {24'd0, press_count[23:16]}, 32'd1);

        // Asynchronous reset during EMIT
        event_ready = 1'b0;
        exp_rd(); exp_wr(2'd3, 32'h1); exp_evt(32'h1);
        press(4'h1);
        wait_valid(20);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, event_valid},    32'd0);
        chk("arst_count", press_count,             32'd0);
        chk("arst_cs",    {31'd0, avm_chipselect}, 32'd0);
        chk("arst_busy",  {31'd0, busy},           32'd0);
        exp_wr(2'd2, 32'h0000_000F);
        @(posedge clk); #1 reset_n = 1'b1; event_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rerst_busy", {31'd0, busy}, 32'd0);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pushbutton_irq_servicer.md
Name: pushbutton_irq_servicer

Overview:
Avalon-MM master (initiator) that services the pushbutton PIO slave: programs its irq_mask, waits for irq, reads edge_capture, clears the captured bits, and presents each service as a button-event handshake. It also keeps per-button saturating press counters. It sits between the pushbutton PIO's s1 slave and fabric logic, such as LED or game control, that must react to button presses without a CPU.

Parameters:
WIDTH, 4, number of buttons; matches the PIO data width.
INIT_MASK, 4'hF, irq_mask value written to the PIO after reset.
CNT_W, 8, width of each per-button saturating press counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avm_address  out  2  PIO register select (0=data, 2=irq_mask, 3=edge_capture)
avm_chipselect  out  1  master access strobe
avm_write_n  out  1  active-low write; reads are chipselect with write_n=1
avm_writedata  out  32  write data; bits above WIDTH are driven 0
avm_readdata  in  32  PIO readdata; registered slave, fixed 1-cycle read latency, no waitrequest
irq  in  1  PIO interrupt, high while (edge_capture & irq_mask) != 0
mask_set  in  1  one-cycle request to rewrite irq_mask
mask_value  in  WIDTH  new mask, sampled when mask_set is accepted
event_valid  out  1  event available
event_ready  in  1  consumer accepts the event when valid & ready
event_buttons  out  WIDTH  buttons pressed in this event (captured & mask)
press_count  out  WIDTH*CNT_W  flattened counters; button i occupies bits [i*CNT_W +: CNT_W]
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, except avm_write_n=1 and avm_address=0. The mask register resets to INIT_MASK. The FSM resets to INIT.
- FSM states: INIT, IDLE, RD_ADDR, RD_WAIT, CLR, EMIT, MASK_WR.
- INIT (1 cycle): chipselect=1, write_n=0, address=2, writedata=mask. Next state is IDLE.
- IDLE:
  - If mask_set is high: latch mask_value into the mask and go to MASK_WR. mask_set has priority over irq in the same cycle.
  - Else if irq is high: go to RD_ADDR.
  - mask_set arriving outside IDLE is ignored. busy signals this.
- MASK_WR (1 cycle): same bus cycle as INIT. Next state is IDLE.
- RD_ADDR (1 cycle): chipselect=1, write_n=1, address=3. Next state is RD_WAIT.
- RD_WAIT (1 cycle): bus idle (chipselect=0). Capture cap = avm_readdata[WIDTH-1:0] & mask. Next state is CLR.
- CLR (1 cycle): chipselect=1, write_n=0, address=3, writedata=cap. Only the bits that were read are cleared, so edges on other bits that arrive between read and clear are preserved.
  - If cap==0 (spurious irq), next state is IDLE.
  - Else next state is EMIT, with event_buttons<=cap and event_valid<=1.
- EMIT: hold event_valid and event_buttons stable until event_ready.
  - On acceptance: event_valid<=0; for each set bit of event_buttons, that counter increments, saturating at 2^CNT_W-1; next state is IDLE.
  - New PIO edges during EMIT stay latched in the PIO and raise irq again. They are serviced after returning to IDLE, so none are lost.
  - A repeat edge on an already-captured bit that occurs between RD_ADDR and CLR is merged into the current event. This is an accepted limitation.
- Bus: chipselect is high only in INIT, MASK_WR, RD_ADDR and CLR. write_n is 0 only in INIT, MASK_WR and CLR. address holds its last value when idle.
- Latency: from irq high in IDLE to event_valid high is 4 cycles.
- Reset mid-operation: asynchronous return to INIT, with counters and event cleared. The mask is rewritten with INIT_MASK.

Decomposition:
- Shared package: state enum; PIO register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3); saturating-increment function.
- One natural sub-module: press_counter_bank, WIDTH saturating CNT_W counters with an increment-mask input.
- FSM and bus driving stay in the top module.

Test Plan:
- Reset release: cycle 0 after reset shows a write to address 2 with writedata=0x0000000F, then IDLE with busy=0.
- Button 1 press: PIO edge_capture=0x2 and irq=1 -> read of address 3, then write of 0x2 to address 3, event_valid=1 with event_buttons=0x2 four cycles after irq. With event_ready=1, press_count[15:8]=1.
- Spurious irq with readdata=0x0 -> read, then clear write of 0x0, no event_valid, back to IDLE.
- mask_set=1 with mask_value=0x5 and irq=1 in the same IDLE cycle -> mask write of 0x5 first, irq serviced after; a later readdata=0xF yields event_buttons=0x5 and a clear of 0x5.
- event_ready held 0 for 10 cycles while button 3 is pressed again -> event stays 0x1 and stable; after accept, a second service yields 0x8 and counters 0 and 3 each equal 1.
- 300 presses of button 0 -> press_count[7:0] saturates at 255. Asserting reset_n=0 during EMIT clears event_valid and all counters asynchronously.
